// File: rtl/mem_access_pkg.sv
// Shared op codes, bus widths and op classification helpers for the memory stage.
// Imported by mem_access and mem_lane_align.
package mem_access_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    localparam logic [3:0] MEM_NOP = 4'd0;
    localparam logic [3:0] MEM_LB  = 4'd1;
    localparam logic [3:0] MEM_LH  = 4'd2;
    localparam logic [3:0] MEM_LW  = 4'd3;
    localparam logic [3:0] MEM_LBU = 4'd4;
    localparam logic [3:0] MEM_LHU = 4'd5;
    localparam logic [3:0] MEM_SB  = 4'd6;
    localparam logic [3:0] MEM_SH  = 4'd7;
    localparam logic [3:0] MEM_SW  = 4'd8;

    function automatic logic is_load(input logic [3:0] op);
        return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
        logic r;
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: r = off[0];
            MEM_LW, MEM_SW:          r = (off != 2'b00);
            default:                 r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
// Latency: purely combinational. Backpressure: none, no state.
// Misaligned halfword/word offsets are truncated to the natural boundary.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        sel   = 4'b0000;
        wdata = st_data;
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: begin
                sel   = 4'b0001 << off;
                wdata = {4{st_data[7:0]}};
            end
            MEM_LH, MEM_LHU, MEM_SH: begin
                sel   = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{st_data[15:0]}};
            end
            MEM_LW, MEM_SW: sel = 4'b1111;
            default: sel = 4'b0000;
        endcase
    end

    always_comb begin
        byte_sel = rdata[{off, 3'b000} +: 8];
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            MEM_LB:  ld_data = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: ld_data = {24'd0, byte_sel};
            MEM_LH:  ld_data = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: ld_data = {16'd0, half_sel};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory stage: drives loads/stores onto a req/ack data bus and forwards write-back to mem_wb.
// Latency: a memory op stalls 2 cycles plus one per ack wait; non-memory ops pass through combinationally.
// Backpressure: stallreq_o holds the pipeline until the DONE cycle. MEM_MISALIGN_TRAP_EN adds misalign_o.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int DATA_W = DATA_WIDTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [4:0]        reg_waddr_i,
    input  logic              reg_we_i,
    input  logic [DATA_W-1:0] reg_wdata_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic [3:0]        mem_op_i,
    input  logic              csr_we_i,
    input  logic [11:0]       csr_waddr_i,
    input  logic [DATA_W-1:0] csr_wdata_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    output logic [3:0]        bus_sel_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic [4:0]        reg_waddr_o,
    output logic              reg_we_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic              csr_we_o,
    output logic [11:0]       csr_waddr_o,
    output logic [DATA_W-1:0] csr_wdata_o,
    output logic              stallreq_o
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic              misalign_o
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        sel_q;
    logic              we_q;
    logic [DATA_W-1:0] ld_q;

    logic [3:0]        lane_sel;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] lane_ld;
    logic              misalign;
    logic              mem_active;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign   = is_misaligned(mem_op_i, mem_addr_i[1:0]);
    assign misalign_o = misalign;
`else
    assign misalign   = 1'b0;
`endif

    // Trapped misaligned ops never touch the bus and never stall.
    assign mem_active = (mem_op_i != MEM_NOP) && !misalign;

    mem_lane_align u_lane_align (
        .op      (mem_op_i),
        .off     (mem_addr_i[1:0]),
        .st_data (mem_data_i),
        .rdata   (bus_rdata_i),
        .sel     (lane_sel),
        .wdata   (lane_wdata),
        .ld_data (lane_ld)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && mem_active) begin
                addr_q  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                wdata_q <= lane_wdata;
                sel_q   <= lane_sel;
                we_q    <= mem_we_i && is_store(mem_op_i);
            end
            if (state_q == ST_BUSY && bus_ack_i) begin
                ld_q <= lane_ld;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mem_active) state_d = ST_BUSY;
            ST_BUSY: if (bus_ack_i)  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus_req_o   = (state_q == ST_BUSY);
        bus_we_o    = we_q;
        bus_addr_o  = addr_q;
        bus_wdata_o = wdata_q;
        bus_sel_o   = sel_q;
        stallreq_o  = mem_active && (state_q != ST_DONE);
    end

    always_comb begin
        reg_waddr_o = '0;
        reg_we_o    = 1'b0;
        reg_wdata_o = '0;
        csr_we_o    = 1'b0;
        csr_waddr_o = '0;
        csr_wdata_o = '0;
        if (rst_i) begin
            reg_waddr_o = reg_waddr_i;
            reg_we_o    = reg_we_i && !stallreq_o && !misalign;
            reg_wdata_o = (is_load(mem_op_i) && state_q == ST_DONE) ? ld_q : reg_wdata_i;
            csr_we_o    = csr_we_i && !stallreq_o;
            csr_waddr_o = csr_waddr_i;
            csr_wdata_o = csr_wdata_i;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed and randomized bench for mem_access against a byte-arithmetic reference model.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  reg_waddr_i;
    logic        reg_we_i;
    logic [31:0] reg_wdata_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [3:0]  mem_op_i;
    logic        csr_we_i;
    logic [11:0] csr_waddr_i;
    logic [31:0] csr_wdata_i;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_sel_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic [4:0]  reg_waddr_o;
    logic        reg_we_o;
    logic [31:0] reg_wdata_o;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        stallreq_o;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk_i = ~clk_i;

    mem_access dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i),
        .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_op_i(mem_op_i),
        .csr_we_i(csr_we_i), .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_sel_o(bus_sel_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
        .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
        .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
        .stallreq_o(stallreq_o)
`ifdef MEM_MISALIGN_TRAP_EN
        , .misalign_o(misalign_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes, naturally aligned offset, lane math.
    function automatic int m_size(input logic [3:0] op);
        if (op == MEM_LB || op == MEM_LBU || op == MEM_SB) return 1;
        if (op == MEM_LH || op == MEM_LHU || op == MEM_SH) return 2;
        return 4;
    endfunction

    function automatic int m_off(input logic [3:0] op, input logic [31:0] addr);
        int s = m_size(op);
        return (int'(addr % 4) / s) * s;
    endfunction

    function automatic logic [3:0] m_sel(input logic [3:0] op, input logic [31:0] addr);
        int s = m_size(op);
        int v = ((1 << s) - 1) << m_off(op, addr);
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] d);
        int s = m_size(op);
        if (s == 1) return {4{d[7:0]}};
        if (s == 2) return {2{d[15:0]}};
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] word);
        int s = m_size(op);
        logic [31:0] mask, v;
        mask = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 32'd1);
        v = (word >> (8 * m_off(op, addr))) & mask;
        if ((op == MEM_LB || op == MEM_LH) && v[8 * s - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic m_is_store(input logic [3:0] op);
        return (op >= MEM_SB) && (op <= MEM_SW);
    endfunction

    // One memory op held stable until the stall drops; ack arrives after wait_n BUSY cycles.
    task automatic mem_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] rdata, input int wait_n);
        int stalls = 0, busy = 0, bad = 0;
        bit done = 0;
        logic st;
        st = m_is_store(op);
        @(negedge clk_i);
        mem_op_i = op; mem_addr_i = addr; mem_data_i = data; mem_we_i = st;
        reg_we_i = !st; reg_waddr_i = 5'($urandom); reg_wdata_i = $urandom;
        csr_we_i = 1'b0; bus_ack_i = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            if (c == 0) begin
                chk("first_stall", 32'(stallreq_o), 32'd1);
                chk("first_reg_we", 32'(reg_we_o), 32'd0);
            end
            if (stallreq_o) stalls++;
            if (bus_req_o) begin
                busy++;
                if (bus_addr_o !== {addr[31:2], 2'b00} || bus_sel_o !== m_sel(op, addr) ||
                    bus_we_o !== st || (st && bus_wdata_o !== m_wdata(op, data))) bad++;
                bus_ack_i   = (busy > wait_n);
                bus_rdata_i = (busy > wait_n) ? rdata : $urandom;
            end else begin
                // acks outside BUSY must be ignored
                bus_ack_i   = stallreq_o ? 1'($urandom) : 1'b0;
                bus_rdata_i = $urandom;
            end
            if (!stallreq_o) begin
                done = 1;
                chk("done_reg_we", 32'(reg_we_o), 32'(!st));
                chk("done_reg_wdata", reg_wdata_o, st ? reg_wdata_i : m_load(op, addr, rdata));
                chk("done_waddr", 32'(reg_waddr_o), 32'(reg_waddr_i));
            end else begin
                @(negedge clk_i);
            end
        end
        bus_ack_i = 1'b0;
        if (!done) chk("op_timeout", 32'd0, 32'd1);
        chk("stall_cycles", 32'(stalls), 32'(wait_n + 2));
        chk("busy_cycles", 32'(busy), 32'(wait_n + 1));
        chk("bus_stable", 32'(bad), 32'd0);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] raddr;
        rst_i = 1'b0; mem_op_i = MEM_NOP; mem_we_i = 1'b0; mem_addr_i = '0; mem_data_i = '0;
        reg_waddr_i = 5'd3; reg_we_i = 1'b1; reg_wdata_i = 32'hDEAD_BEEF;
        csr_we_i = 1'b1; csr_waddr_i = 12'h123; csr_wdata_i = 32'h55;
        bus_ack_i = 1'b0; bus_rdata_i = '0;

        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_bus_req", 32'(bus_req_o), 32'd0);
        chk("rst_bus_sel", 32'(bus_sel_o), 32'd0);
        chk("rst_bus_addr", bus_addr_o, 32'd0);
        chk("rst_reg_we", 32'(reg_we_o), 32'd0);
        chk("rst_reg_wdata", reg_wdata_o, 32'd0);
        chk("rst_csr_we", 32'(csr_we_o), 32'd0);
        rst_i = 1'b1;

        // Non-memory ADD, then CSR write, then LW back to back.
        @(negedge clk_i);
        csr_we_i = 1'b0; reg_we_i = 1'b1; reg_waddr_i = 5'd7; reg_wdata_i = 32'h0000_1234;
        #1;
        chk("add_stall", 32'(stallreq_o), 32'd0);
        chk("add_reg_we", 32'(reg_we_o), 32'd1);
        chk("add_reg_wdata", reg_wdata_o, 32'h0000_1234);
        chk("add_reg_waddr", 32'(reg_waddr_o), 32'd7);
        @(negedge clk_i);
        reg_we_i = 1'b0; csr_we_i = 1'b1; csr_waddr_i = 12'h300; csr_wdata_i = 32'h8;
        #1;
        chk("csr_stall", 32'(stallreq_o), 32'd0);
        chk("csr_we", 32'(csr_we_o), 32'd1);
        chk("csr_waddr", 32'(csr_waddr_o), 32'h300);
        chk("csr_wdata", csr_wdata_o, 32'h8);
        mem_op(MEM_LW, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 0);

        mem_op(MEM_SB,  32'h0000_1003, 32'h0000_00A5, 32'h0, 0);
        mem_op(MEM_LB,  32'h0000_2001, 32'h0, 32'h0000_8000, 0);
        mem_op(MEM_LBU, 32'h0000_2001, 32'h0, 32'h0000_8000, 0);
        mem_op(MEM_LH,  32'h0000_2002, 32'h0, 32'h1234_ABCD, 3);
        mem_op(MEM_SH,  32'h0000_2006, 32'h0000_BEEF, 32'h0, 1);

        // Reset in the middle of BUSY; a late ack after release must be ignored.
        @(negedge clk_i);
        mem_op_i = MEM_LH; mem_addr_i = 32'h0000_2002; reg_we_i = 1'b1; mem_we_i = 1'b0; bus_ack_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        chk("pre_rst_busy", 32'(bus_req_o), 32'd1);
        rst_i = 1'b0; mem_op_i = MEM_NOP;
        @(negedge clk_i);
        #1;
        chk("midrst_bus_req", 32'(bus_req_o), 32'd0);
        chk("midrst_bus_sel", 32'(bus_sel_o), 32'd0);
        chk("midrst_bus_addr", bus_addr_o, 32'd0);
        chk("midrst_reg_we", 32'(reg_we_o), 32'd0);
        rst_i = 1'b1; bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk_i);
        #1;
        chk("late_ack_req", 32'(bus_req_o), 32'd0);
        chk("late_ack_stall", 32'(stallreq_o), 32'd0);
        bus_ack_i = 1'b0;

`ifdef MEM_MISALIGN_TRAP_EN
        @(negedge clk_i);
        mem_op_i = MEM_LW; mem_addr_i = 32'h0000_3002; reg_we_i = 1'b1; mem_we_i = 1'b0;
        #1;
        chk("mis_flag", 32'(misalign_o), 32'd1);
        chk("mis_stall", 32'(stallreq_o), 32'd0);
        chk("mis_reg_we", 32'(reg_we_o), 32'd0);
        @(negedge clk_i);
        #1;
        chk("mis_bus_req", 32'(bus_req_o), 32'd0);
`else
        mem_op(MEM_LW, 32'h0000_3002, 32'h0, 32'h8765_4321, 0);
`endif

        for (int i = 0; i < 30; i++) begin
            rop   = 4'($urandom_range(1, 8));
            raddr = $urandom;
`ifdef MEM_MISALIGN_TRAP_EN
            raddr = raddr & ~32'(m_size(rop) - 1);
`endif
            mem_op(rop, raddr, $urandom, $urandom, $urandom_range(0, 3));
        end

        @(negedge clk_i);
        mem_op_i = MEM_NOP;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
